// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART memory loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_FINISH,
    S_RELEASE,
    S_ERROR
  } loader_state_e;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam int         UART_DATA_BITS   = 8;

endpackage

// File: rtl/loader_uart_rx.sv
// UART receiver for the boot loader: 8N1, mid-bit sampling, glitch-rejecting start bit.
module loader_uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e      state, next_state;
  logic           rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           bit_tick;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    bit_tick   = (state == RX_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) next_state = RX_START;
      RX_START: if (bit_tick) next_state = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'(UART_DATA_BITS - 1)) next_state = RX_STOP;
      RX_STOP:  if (bit_tick) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= RX_IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_meta      <= rx_i;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      cnt          <= (state == RX_IDLE || bit_tick) ? '0 : cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && bit_tick) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == RX_STOP && bit_tick) begin
        byte_o       <= shift;
        byte_valid_o <= rx_sync;
        frame_err_o  <= !rx_sync;
      end
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// UART boot loader writing little-endian words into memory port A while holding the core in reset.
// Optional trailing XOR checksum byte enabled with `define LOADER_CHECKSUM_EN.
module uart_mem_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int ADDR_WIDTH  = 16,
  parameter int NB_COL      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  uart_rx_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [NB_COL-1:0]     mem_we_o,
  output logic                  core_rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e S_AFTER_DATA = S_CSUM;
  logic [7:0] csum;
`else
  localparam loader_state_e S_AFTER_DATA = S_FINISH;
`endif

  loader_state_e         state, next_state;
  logic [7:0]            rx_byte;
  logic                  rx_valid, rx_err, is_sync;
  logic [7:0]            len_lo;
  logic [15:0]           remaining;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_lo;
  logic [ADDR_WIDTH-1:0] word_addr;

  loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  assign is_sync = rx_valid && (rx_byte == LOADER_SYNC_BYTE);

  // Framing errors only abort a frame in progress; idle and error states just wait for sync.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_ERROR: if (is_sync) next_state = S_LEN0;
      S_LEN0:   if (rx_err) next_state = S_ERROR;
                else if (rx_valid) next_state = S_LEN1;
      S_LEN1:   if (rx_err) next_state = S_ERROR;
                else if (rx_valid) next_state = ({rx_byte, len_lo} == 16'd0) ? S_AFTER_DATA : S_DATA;
      S_DATA:   if (rx_err) next_state = S_ERROR;
                else if (rx_valid && byte_cnt == 2'd3 && remaining == 16'd1) next_state = S_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:   if (rx_err) next_state = S_ERROR;
                else if (rx_valid) next_state = (rx_byte == csum) ? S_FINISH : S_ERROR;
`endif
      S_FINISH:  next_state = S_RELEASE;
      S_RELEASE: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_we_o     <= '0;
      core_rst_n_o <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      len_lo       <= '0;
      remaining    <= '0;
      byte_cnt     <= '0;
      word_lo      <= '0;
      word_addr    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we_o <= '0;
      case (state)
        S_IDLE, S_ERROR: if (is_sync) begin
          core_rst_n_o <= 1'b0;
          busy_o       <= 1'b1;
          done_o       <= 1'b0;
          error_o      <= 1'b0;
          word_addr    <= '0;
          byte_cnt     <= '0;
        end
        S_LEN0: if (rx_valid) len_lo <= rx_byte;
        S_LEN1: if (rx_valid) remaining <= {rx_byte, len_lo};
        S_DATA: if (rx_valid) begin
          byte_cnt <= byte_cnt + 1'b1;
          word_lo  <= {rx_byte, word_lo[23:8]};
          if (byte_cnt == 2'd3) begin
            mem_we_o    <= '1;
            mem_wdata_o <= {rx_byte, word_lo};
            mem_addr_o  <= word_addr;
            word_addr   <= word_addr + 1'b1;
            remaining   <= remaining - 1'b1;
          end
        end
        S_FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        S_RELEASE: core_rst_n_o <= 1'b1;
        default: ;
      endcase
      if (next_state == S_ERROR && state != S_ERROR) begin
        error_o <= 1'b1;
        busy_o  <= 1'b0;
      end
`ifdef LOADER_CHECKSUM_EN
      if ((state == S_IDLE || state == S_ERROR) && is_sync) csum <= '0;
      else if (rx_valid && (state == S_LEN0 || state == S_LEN1 || state == S_DATA))
        csum <= csum ^ rx_byte;
`endif
    end
  end

endmodule
